// File: rtl/conv_pkg.sv
// Shared defaults and elaboration helpers for the KxK convolution core:
// adder-tree geometry (depth, per-level node counts, flat node offsets) and tap packing.
package conv_pkg;

   localparam int unsigned DW_DEF    = 8;
   localparam int unsigned K_DEF     = 3;
   localparam int unsigned OUT_W_DEF = 32;

   function automatic int unsigned tree_depth(input int unsigned ntap);
      return $clog2(ntap);
   endfunction

   // Width that holds the full dot product without overflow.
   function automatic int unsigned sum_width(input int unsigned dw, input int unsigned ntap);
      return 2 * dw + tree_depth(ntap);
   endfunction

   // Number of nodes at tree level lvl (level 0 = products).
   function automatic int unsigned tree_cnt(input int unsigned ntap, input int unsigned lvl);
      return (ntap + (32'd1 << lvl) - 32'd1) >> lvl;
   endfunction

   // Flat index of the first node of level lvl (levels 1..L stored back to back).
   function automatic int unsigned tree_off(input int unsigned ntap, input int unsigned lvl);
      int unsigned off;
      off = 0;
      for (int unsigned m = 1; m < lvl; m++) begin
         off += tree_cnt(ntap, m);
      end
      return off;
   endfunction

   function automatic int unsigned tree_nodes(input int unsigned ntap);
      return tree_off(ntap, tree_depth(ntap) + 1);
   endfunction

   // Tap 0 sits in the MSBs of the packed window.
   function automatic int unsigned tap_lsb(input int unsigned ntap, input int unsigned dw,
                                           input int unsigned tap);
      return (ntap - 1 - tap) * dw;
   endfunction

endpackage

// File: rtl/conv_mac_tap.sv
// One registered DWxDW multiplier; operands sign- or zero-extended per beat, held while stalled.
module conv_mac_tap
   import conv_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              signed_mode,
   input  logic [DW-1:0]     a,
   input  logic [DW-1:0]     b,
   output logic [2*DW-1:0]   p_q
);

   logic [2*DW-1:0] a_x;
   logic [2*DW-1:0] b_x;
   logic [2*DW-1:0] p_d;

   // Low 2*DW bits of the extended product equal the exact signed or unsigned product.
   always_comb begin
      if (signed_mode) begin
         a_x = {{DW{a[DW-1]}}, a};
         b_x = {{DW{b[DW-1]}}, b};
      end else begin
         a_x = {{DW{1'b0}}, a};
         b_x = {{DW{1'b0}}, b};
      end
      p_d = a_x * b_x;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q <= '0;
      end else if (en) begin
         p_q <= p_d;
      end
   end

endmodule

// File: rtl/conv_core_kxk.sv
// Pipelined KxK convolution MAC: multiply stage, registered adder tree, channel accumulator.
// Define CONV_CORE_RELU_EN to clamp negative signed results to zero in the output register.
module conv_core_kxk
   import conv_pkg::*;
#(
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned K     = K_DEF,
   parameter int unsigned OUT_W = OUT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_first,
   input  logic                 in_last,
   input  logic [K*K*DW-1:0]    image,
   input  logic [K*K*DW-1:0]    filter,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_W-1:0]     conv_out
);

   localparam int unsigned NTAP  = K * K;
   localparam int unsigned L     = tree_depth(NTAP);
   localparam int unsigned PW    = 2 * DW;
   localparam int unsigned SW    = sum_width(DW, NTAP);
   localparam int unsigned NNODE = tree_nodes(NTAP);
   localparam int unsigned ROOT  = NNODE - 1;

   logic              en;
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  conv_out_q, conv_out_d;
   logic [OUT_W-1:0]  acc_q, acc_d;
   logic [OUT_W-1:0]  root_ext;
   logic [OUT_W-1:0]  acc_sum;
   logic signed [SW-1:0] root_s;

   // Per-stage beat flags: index 0 = multiply stage, index L = last tree level.
   logic [L:0] v_q, v_d;
   logic [L:0] f_q, f_d;
   logic [L:0] lst_q, lst_d;
   logic [L:0] s_q, s_d;

   logic [PW-1:0] prod [NTAP];
   logic [SW-1:0] leaf [NTAP];
   logic [SW-1:0] node_q [NNODE];
   logic [SW-1:0] node_d [NNODE];

   assign en        = !(out_valid_q && !out_ready);
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign conv_out  = conv_out_q;

   for (genvar i = 0; i < NTAP; i++) begin : g_tap
      conv_mac_tap #(.DW(DW)) u_tap (
         .clk         (clk),
         .rst         (rst),
         .en          (en),
         .signed_mode (signed_mode),
         .a           (image[tap_lsb(NTAP, DW, i) +: DW]),
         .b           (filter[tap_lsb(NTAP, DW, i) +: DW]),
         .p_q         (prod[i])
      );
   end

   always_comb begin
      for (int unsigned i = 0; i < NTAP; i++) begin
         leaf[i] = {{L{s_q[0] & prod[i][PW-1]}}, prod[i]};
      end
   end

   // Tree held at full sum width throughout; extending once at the leaves is equivalent to
   // extending by one bit per level, and an odd node simply passes through (adds zero).
   for (genvar lv = 1; lv <= L; lv++) begin : g_lv
      localparam int unsigned NC   = tree_cnt(NTAP, lv);
      localparam int unsigned NP   = tree_cnt(NTAP, lv - 1);
      localparam int unsigned OFF  = tree_off(NTAP, lv);
      localparam int unsigned POFF = tree_off(NTAP, lv - 1);
      for (genvar j = 0; j < NC; j++) begin : g_n
         logic [SW-1:0] opa;
         logic [SW-1:0] opb;
         if (lv == 1) begin : g_leaf
            assign opa = leaf[2*j];
            if (2*j + 1 < NP) begin : g_pair
               assign opb = leaf[2*j + 1];
            end else begin : g_odd
               assign opb = '0;
            end
         end else begin : g_inner
            assign opa = node_q[POFF + 2*j];
            if (2*j + 1 < NP) begin : g_pair
               assign opb = node_q[POFF + 2*j + 1];
            end else begin : g_odd
               assign opb = '0;
            end
         end
         assign node_d[OFF + j] = opa + opb;
      end
   end

   always_comb begin
      v_d   = {v_q[L-1:0], in_valid};
      f_d   = {f_q[L-1:0], in_first};
      lst_d = {lst_q[L-1:0], in_last};
      s_d   = {s_q[L-1:0], signed_mode};
   end

   assign root_s = node_q[ROOT];

   always_comb begin
      if (s_q[L]) begin
         root_ext = OUT_W'(root_s);
      end else begin
         root_ext = OUT_W'(node_q[ROOT]);
      end
      acc_sum = (f_q[L] ? '0 : acc_q) + root_ext;

      acc_d       = acc_q;
      conv_out_d  = conv_out_q;
      out_valid_d = out_valid_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      // Emitting clears the accumulator so a following beat without first starts from zero.
      if (en && v_q[L]) begin
         if (lst_q[L]) begin
            acc_d       = '0;
            out_valid_d = 1'b1;
            conv_out_d  = acc_sum;
`ifdef CONV_CORE_RELU_EN
            if (s_q[L] && acc_sum[OUT_W-1]) begin
               conv_out_d = '0;
            end
`endif
         end else begin
            acc_d = acc_sum;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q         <= '0;
         f_q         <= '0;
         lst_q       <= '0;
         s_q         <= '0;
         node_q      <= '{default: '0};
         acc_q       <= '0;
         conv_out_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (en) begin
            v_q    <= v_d;
            f_q    <= f_d;
            lst_q  <= lst_d;
            s_q    <= s_d;
            node_q <= node_d;
         end
         acc_q       <= acc_d;
         conv_out_q  <= conv_out_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_conv_core_kxk.sv
// Directed self-checking bench for conv_core_kxk at K=3, DW=8, OUT_W=32.
module tb_conv_core_kxk;

   logic        clk;
   logic        rst;
   logic        signed_mode;
   logic        in_valid;
   logic        in_ready;
   logic        in_first;
   logic        in_last;
   logic [71:0] image;
   logic [71:0] filter;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] conv_out;

   int ncmp;
   int nerr;

   conv_core_kxk #(.DW(8), .K(3), .OUT_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .signed_mode (signed_mode),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_first    (in_first),
      .in_last     (in_last),
      .image       (image),
      .filter      (filter),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .conv_out    (conv_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [71:0] im;
      logic [71:0] fl;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 11;
   vec_t tv [NV];

   function automatic logic [71:0] rep(input logic [7:0] b);
      return {9{b}};
   endfunction

   function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef CONV_CORE_RELU_EN
      return v[31] ? 32'd0 : v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", nm, act, act, exp, exp);
      end
   endtask

   // Drives a beat at the falling edge and holds it until the core takes it.
   task automatic send(input logic s, input logic f, input logic l,
                       input logic [71:0] im, input logic [71:0] fl);
      logic acc;
      acc = 1'b0;
      @(negedge clk);
      signed_mode = s;
      in_first    = f;
      in_last     = l;
      image       = im;
      filter      = fl;
      in_valid    = 1'b1;
      for (int n = 0; n < 64; n++) begin
         #4;
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         @(negedge clk);
      end
      check("send_accept", 32'(acc), 32'd1);
   endtask

   task automatic wait_res(input string nm, input logic [31:0] exp, input int exp_lat);
      int lat;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({nm, "_valid"}, 32'(out_valid), 32'd1);
      check({nm, "_data"}, conv_out, exp);
      check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic quiet(input string nm, input int n);
      int cnt;
      cnt = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (out_valid) cnt++;
      end
      check(nm, 32'(cnt), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int got;
   int lowc;

   initial begin
      logic [71:0] seq;
      logic [71:0] alt;
      logic [71:0] t0;
      logic [71:0] t8;
      ncmp = 0;
      nerr = 0;
      seq = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      alt = {8'hFF, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'hFF};
      t0  = {8'd3, 64'd0};
      t8  = {64'd0, 8'd7};

      tv[0]  = '{s: 1'b0, im: rep(8'h01), fl: rep(8'h01), exp: 32'd9};
      tv[1]  = '{s: 1'b1, im: rep(8'hFF), fl: rep(8'h02), exp: relu(32'hFFFF_FFEE)};
      tv[2]  = '{s: 1'b0, im: rep(8'hFF), fl: rep(8'hFF), exp: 32'd585225};
      tv[3]  = '{s: 1'b1, im: rep(8'h80), fl: rep(8'h80), exp: 32'd147456};
      tv[4]  = '{s: 1'b1, im: rep(8'h80), fl: rep(8'h7F), exp: relu(32'hFFFD_C480)};
      tv[5]  = '{s: 1'b0, im: rep(8'h80), fl: rep(8'h7F), exp: 32'd146304};
      tv[6]  = '{s: 1'b0, im: seq,        fl: rep(8'h01), exp: 32'd45};
      tv[7]  = '{s: 1'b0, im: seq,        fl: seq,        exp: 32'd285};
      tv[8]  = '{s: 1'b1, im: seq,        fl: alt,        exp: relu(32'hFFFF_FFFB)};
      tv[9]  = '{s: 1'b0, im: rep(8'hFF), fl: rep(8'h02), exp: 32'd4590};
      tv[10] = '{s: 1'b0, im: t0 | t8,    fl: {8'd5, 56'd0, 8'd6}, exp: 32'd57};

      rst = 1'b1;
      signed_mode = 1'b0;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last = 1'b0;
      image = '0;
      filter = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_conv_out", conv_out, 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Single-channel beats: result K=3 arrives 5 edges after the accepting edge.
      for (int i = 0; i < NV; i++) begin
         send(tv[i].s, 1'b1, 1'b1, tv[i].im, tv[i].fl);
         in_valid = 1'b0;
         wait_res($sformatf("vec%0d", i), tv[i].exp, 5);
      end
      quiet("vec_extra", 8);

      // Three channels of all-0xFF, then a lone last beat that must start from zero.
      send(1'b0, 1'b1, 1'b0, rep(8'hFF), rep(8'hFF));
      send(1'b0, 1'b0, 1'b0, rep(8'hFF), rep(8'hFF));
      send(1'b0, 1'b0, 1'b1, rep(8'hFF), rep(8'hFF));
      in_valid = 1'b0;
      wait_res("multi", 32'd1755675, 5);
      quiet("multi_extra", 10);
      send(1'b0, 1'b0, 1'b1, rep(8'h01), rep(8'h01));
      in_valid = 1'b0;
      wait_res("after_emit", 32'd9, 5);

      // Reset between first and last drops the open pixel.
      send(1'b0, 1'b1, 1'b0, rep(8'h01), rep(8'h01));
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_conv_out", conv_out, 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      quiet("midrst_quiet", 12);
      send(1'b0, 1'b1, 1'b0, rep(8'h01), rep(8'h01));
      send(1'b0, 1'b0, 1'b1, rep(8'h03), rep(8'h01));
      in_valid = 1'b0;
      wait_res("midrst_after", 32'd36, 5);

      // A second first discards the open sum.
      send(1'b0, 1'b1, 1'b0, rep(8'hFF), rep(8'hFF));
      send(1'b0, 1'b0, 1'b0, rep(8'hFF), rep(8'hFF));
      send(1'b0, 1'b1, 1'b0, rep(8'h01), rep(8'h01));
      send(1'b0, 1'b0, 1'b1, rep(8'h02), rep(8'h01));
      in_valid = 1'b0;
      wait_res("refirst", 32'd27, 5);
      quiet("refirst_extra", 10);

      // Back-to-back beats with the first result held off for five cycles.
      out_ready = 1'b0;
      got = 0;
      lowc = 0;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               send(1'b0, 1'b1, 1'b1, rep(8'(k + 1)), rep(8'h01));
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 200 && got < 8; c++) begin
               @(negedge clk);
               if (out_valid && !out_ready) begin
                  check("stall_hold", conv_out, 32'd9);
                  check("stall_in_ready", 32'(in_ready), 32'd0);
                  lowc++;
                  if (lowc == 5) out_ready = 1'b1;
               end
               if (out_valid && out_ready) begin
                  check($sformatf("order%0d", got), conv_out, 32'(9 * (got + 1)));
                  got++;
               end
            end
         end
      join
      check("stall_cycles", 32'(lowc), 32'd5);
      check("stall_count", 32'(got), 32'd8);
      quiet("stall_extra", 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
